// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle RV32-subset core: opcodes, FSM states, ALU ops
// and the instruction legality / ALU-op decode helpers.
package proc_pkg;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_SYS = 7'h73;

  typedef enum logic [2:0] {
    StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt, StIllegal
  } state_e;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluSlt
  } alu_op_e;

  // SYSTEM counts as legal here; the FSM routes it to the halt state.
  function automatic logic insn_legal(input logic [6:0] opcode, input logic [2:0] funct3,
                                      input logic [6:0] funct7);
    logic ok;
    case (opcode)
      OP_R:   ok = (funct7 == 7'h00 && funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ||
                   (funct7 == 7'h20 && funct3 == 3'b000);
      OP_I:   ok = (funct3 == 3'b000);
      OP_LW:  ok = (funct3 == 3'b010);
      OP_SW:  ok = (funct3 == 3'b010);
      OP_BR:  ok = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_JAL: ok = 1'b1;
      OP_SYS: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_e alu_decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                         input logic [6:0] funct7);
    alu_op_e op;
    op = AluAdd;
    if (opcode == OP_R) begin
      case (funct3)
        3'b000:  op = funct7[5] ? AluSub : AluAdd;
        3'b111:  op = AluAnd;
        3'b110:  op = AluOr;
        3'b010:  op = AluSlt;
        default: op = AluAdd;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// Register file: NUM_REGS x XLEN, two asynchronous read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes.
module proc_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2_i,
  output logic [XLEN-1:0]             rdata1_o,
  output logic [XLEN-1:0]             rdata2_o,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [XLEN-1:0]             wdata_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/multi_cycle_processor.sv
// Multi-cycle RV32-subset core with a single req/ready memory port.
// Optional performance counters are enabled by defining MULTI_CYCLE_PERF_CNT_EN.
module multi_cycle_processor
  import proc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic            illegal
`ifdef MULTI_CYCLE_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
`endif
);

  localparam int unsigned     AW   = $clog2(NUM_REGS);
  localparam logic [XLEN-1:0] Four = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, aluout_q, aluout_d, mdr_q, mdr_d;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_val, alu_b, alu_res, rf_rd1, rf_rd2, rf_wd;
  logic            rf_we, br_taken;
  alu_op_e         alu_op;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  proc_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .raddr1_i (ir_q[15 +: AW]),
    .raddr2_i (ir_q[20 +: AW]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2),
    .we_i     (rf_we),
    .waddr_i  (ir_q[7 +: AW]),
    .wdata_i  (rf_wd)
  );

  always_comb begin
    case (opcode)
      OP_SW:   imm_val = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BR:   imm_val = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_JAL:  imm_val = {{(XLEN-20){ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm_val = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  assign alu_op   = alu_decode(opcode, funct3, funct7);
  assign alu_b    = (opcode == OP_R) ? b_q : imm_q;
  // funct3[0] distinguishes bne from beq.
  assign br_taken = (a_q == b_q) ^ funct3[0];

  always_comb begin
    unique case (alu_op)
      AluSub:  alu_res = a_q - alu_b;
      AluAnd:  alu_res = a_q & alu_b;
      AluOr:   alu_res = a_q | alu_b;
      AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
      default: alu_res = a_q + alu_b;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    oldpc_d   = oldpc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    rf_wd     = '0;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          oldpc_d = pc_q;
          pc_d    = pc_q + Four;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d   = rf_rd1;
        b_d   = rf_rd2;
        imm_d = imm_val;
        if (opcode == OP_SYS)                       state_d = StHalt;
        else if (!insn_legal(opcode, funct3, funct7)) state_d = StIllegal;
        else                                        state_d = StExec;
      end
      StExec: begin
        aluout_d = alu_res;
        case (opcode)
          OP_BR: begin
            if (br_taken) pc_d = oldpc_q + imm_q;
            state_d = StFetch;
          end
          OP_JAL: begin
            rf_we   = 1'b1;
            rf_wd   = oldpc_q + Four;
            pc_d    = oldpc_q + imm_q;
            state_d = StFetch;
          end
          OP_LW, OP_SW: state_d = (alu_res[1:0] != 2'b00) ? StIllegal : StMem;
          default:      state_d = StWb;
        endcase
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_we    = (opcode == OP_SW);
        mem_addr  = aluout_q;
        mem_wdata = b_q;
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        rf_wd   = (opcode == OP_LW) ? mdr_q : aluout_q;
        state_d = StFetch;
      end
      StHalt:    state_d = StHalt;
      StIllegal: state_d = StIllegal;
      default:   state_d = StIllegal;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  assign halted  = (state_q == StHalt);
  assign illegal = (state_q == StIllegal);

`ifdef MULTI_CYCLE_PERF_CNT_EN
  logic [XLEN-1:0] cycle_cnt_q, instret_cnt_q;
  logic            active, retire;

  assign active = state_q inside {StFetch, StDecode, StExec, StMem, StWb};
  // An instruction retires when its last state hands control back to FETCH.
  assign retire = (state_d == StFetch) && (state_q inside {StExec, StMem, StWb});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (active) cycle_cnt_q <= cycle_cnt_q + XLEN'(1);
      if (retire) instret_cnt_q <= instret_cnt_q + XLEN'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/multi_cycle_processor.md
Name: multi_cycle_processor

Overview:
- Parametrised multi-cycle RV32-subset core; successor to the single-cycle processor.
- Executes one instruction over 3-5 FSM states.
- Uses a single unified memory port with a req/ready handshake, so instruction and data memories may have variable latency.
- Adds reset, halt/illegal reporting, and bne/jal/halt support.
- Top-level CPU of the lab system; the memory model sits outside.

Parameters:
- XLEN, 32: datapath, register and address width.
- NUM_REGS, 32: register count (power of two, 2..32); rd/rs indices truncated to clog2(NUM_REGS) bits.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  XLEN  byte address, word-aligned.
- mem_wdata  output  XLEN  store data.
- mem_rdata  input  XLEN  read data; valid in the cycle mem_ready=1.
- mem_ready  input  1  access completes this cycle; ignored while mem_req=0.
- halted  output  1  core stopped on SYSTEM opcode (0x73).
- illegal  output  1  core stopped on unsupported opcode/funct or misaligned load/store.

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT; PC=RESET_PC; IR=0; all registers=0.
  - All outputs 0; mem_req drops immediately, even mid-transaction.
  - BOOT->FETCH on the first clk edge with rst_n=1.
- Instruction set:
  - R-type add/sub/and/or/slt.
  - addi, lw, sw, beq, bne, jal.
  - opcode 0x73 = halt.
  - Anything else is illegal.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Hold until mem_ready; then IR<=mem_rdata, OLDPC<=PC, PC<=PC+4, ->DECODE.
- DECODE:
  - A<=rs1, B<=rs2, IMM<=sign-extended immediate (I/S/B/J formats).
  - Unsupported -> ILLEGAL; SYSTEM -> HALT.
- EXEC:
  - ALU result latched into ALUOUT.
  - beq/bne: if taken, PC<=OLDPC+IMM; ->FETCH.
  - jal: rd<=OLDPC+4, PC<=OLDPC+IMM; ->FETCH.
  - lw/sw: if ALU address[1:0]!=0 -> ILLEGAL, else ->MEM.
  - R/addi: ->WB.
- MEM:
  - mem_req=1, mem_addr=ALUOUT, mem_we=(sw), mem_wdata=B.
  - On mem_ready: lw -> MDR<=mem_rdata, ->WB; sw -> FETCH.
- WB: rd<=ALUOUT (or MDR for lw); ->FETCH.
- HALT / ILLEGAL:
  - Terminal states; corresponding flag =1; mem_req=0.
  - Only reset exits.
- Register x0:
  - Always reads 0; writes to it are discarded.
  - A write and a read of the same register in one cycle returns the old value; no bypass is needed because of the FSM spacing.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN; PC wraps silently.
  - slt is signed.
  - sub is selected by funct7[5].
- Cycle counts with zero-wait memory (mem_ready tied 1): beq/bne/jal 3, R/addi/sw 4, lw 5. Each extra wait cycle adds 1.
- mem_req/mem_we/mem_addr/mem_wdata are held stable until mem_ready.

Optional Feature:
- Macro: MULTI_CYCLE_PERF_CNT_EN.
- When defined, adds two output ports, each XLEN wide:
  - cycle_cnt: increments every cycle outside BOOT/HALT/ILLEGAL.
  - instret_cnt: increments on each instruction's final state transition.
  - Both reset to 0 and wrap.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package proc_pkg holds:
  - opcode constants (OP_R=0x33, OP_I=0x13, OP_LW=0x03, OP_SW=0x23, OP_BR=0x63, OP_JAL=0x6F, OP_SYS=0x73);
  - the FSM state enum (BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT, ILLEGAL);
  - ALU op encodings.
- One sub-module, proc_regfile: NUM_REGS x XLEN, 2 async read ports, 1 sync write port, x0 forced to zero, async reset.

Test Plan:
- addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; halt, zero-wait memory -> x3=12; halted=1 after exactly 4+4+4+3 cycles past BOOT.
- sw x3,8(x0) then lw x4,8(x0), with memory inserting 2 wait cycles per access -> x4=12; lw takes 5+2+2 cycles; mem_addr/mem_we stable during the waits.
- beq x1,x1,+8 skips the next instruction; bne x1,x1,+8 falls through -> PC sequence 0,8 then 12,16; addi x0,x0,9 -> x0 reads 0.
- jal x5,-4 at PC 0x10 -> x5=0x14, next fetch address 0x0C.
- Fetch of 0xFFFFFFFF -> illegal=1, mem_req stays 0; lw at address 6 -> illegal=1, no MEM request issued.
- rst_n asserted mid-MEM with mem_req=1 -> mem_req=0 in the same cycle; after release, first fetch from RESET_PC. With MULTI_CYCLE_PERF_CNT_EN defined, counters read 0.
